// File: rtl/inst_fetch_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between two fetch ways.
// One transaction outstanding; flushes cancel or drain the in-flight fetch.
module inst_fetch_arbiter #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int MaxWait   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 way0_request_i,
  input  logic [AddrWidth-1:0] way0_addr_i,
  output logic                 way0_grant_o,
  output logic                 way0_dataOk_o,
  output logic [DataWidth-1:0] way0_inst_o,
  input  logic                 way1_request_i,
  input  logic [AddrWidth-1:0] way1_addr_i,
  output logic                 way1_grant_o,
  output logic                 way1_dataOk_o,
  output logic [DataWidth-1:0] way1_inst_o,
  output logic                 mem_request_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_dataOk_i,
  input  logic [DataWidth-1:0] mem_inst_i,
  output logic                 timeout_o
);

  localparam int CntWidth = $clog2(MaxWait + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t               state, state_next;
  logic                 owner, owner_next;
  logic                 last_grant;
  logic [CntWidth-1:0]  wait_cnt, wait_cnt_next;
  logic [AddrWidth-1:0] addr_q;
  logic                 start;
  logic                 deliver;
  logic                 timeout_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // owner: 0 = way0, 1 = way1. A response is delivered only from WAIT/REQ with no flush.
  always_comb begin
    state_next    = state;
    owner_next    = owner;
    wait_cnt_next = wait_cnt;
    start         = 1'b0;
    deliver       = 1'b0;
    timeout_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!flush_i && (way0_request_i || way1_request_i)) begin
          start         = 1'b1;
          state_next    = REQ;
          wait_cnt_next = '0;
          if (way0_request_i && way1_request_i) begin
            owner_next = ~last_grant;
          end else begin
            owner_next = way1_request_i;
          end
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (flush_i) begin
            state_next = mem_dataOk_i ? IDLE : DROP;
          end else if (mem_dataOk_i) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT;
          end
        end else if (flush_i) begin
          state_next = IDLE;
        end
      end
      WAIT, DROP: begin
        wait_cnt_next = wait_cnt + CntWidth'(1);
        if (mem_dataOk_i) begin
          deliver    = (state == WAIT) && !flush_i;
          state_next = IDLE;
        end else if (wait_cnt == CntWidth'(MaxWait - 1)) begin
          timeout_set = 1'b1;
          state_next  = IDLE;
        end else if (flush_i) begin
          state_next = DROP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      wait_cnt      <= '0;
      addr_q        <= '0;
      way0_dataOk_o <= 1'b0;
      way1_dataOk_o <= 1'b0;
      way0_inst_o   <= '0;
      way1_inst_o   <= '0;
      timeout_o     <= 1'b0;
    end else begin
      owner         <= owner_next;
      wait_cnt      <= wait_cnt_next;
      way0_dataOk_o <= deliver && !owner;
      way1_dataOk_o <= deliver && owner;
      timeout_o     <= timeout_set;
      if (start) begin
        addr_q <= owner_next ? way1_addr_i : way0_addr_i;
      end
      if (deliver) begin
        last_grant <= owner;
        if (owner) begin
          way1_inst_o <= mem_inst_i;
        end else begin
          way0_inst_o <= mem_inst_i;
        end
      end
    end
  end

  assign mem_request_o = (state == REQ);
  assign mem_addr_o    = addr_q;
  assign way0_grant_o  = ((state == REQ) || (state == WAIT)) && !owner;
  assign way1_grant_o  = ((state == REQ) || (state == WAIT)) && owner;

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Directed self-checking bench for inst_fetch_arbiter; inputs change and outputs
// are checked on the falling edge, away from the active rising edge.
module tb_inst_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        way0_request_i, way1_request_i;
  logic [31:0] way0_addr_i, way1_addr_i;
  logic        way0_grant_o, way1_grant_o;
  logic        way0_dataOk_o, way1_dataOk_o;
  logic [31:0] way0_inst_o, way1_inst_o;
  logic        mem_request_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i, mem_dataOk_i;
  logic [31:0] mem_inst_i;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  inst_fetch_arbiter #(.DataWidth(32), .AddrWidth(32), .MaxWait(15)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .way0_request_i(way0_request_i), .way0_addr_i(way0_addr_i),
    .way0_grant_o(way0_grant_o), .way0_dataOk_o(way0_dataOk_o), .way0_inst_o(way0_inst_o),
    .way1_request_i(way1_request_i), .way1_addr_i(way1_addr_i),
    .way1_grant_o(way1_grant_o), .way1_dataOk_o(way1_dataOk_o), .way1_inst_o(way1_inst_o),
    .mem_request_o(mem_request_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_dataOk_i(mem_dataOk_i), .mem_inst_i(mem_inst_i),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic flush, input logic r0, input logic [31:0] a0,
                               input logic r1, input logic [31:0] a1,
                               input logic ack, input logic dok, input logic [31:0] inst);
    flush_i        = flush;
    way0_request_i = r0;
    way0_addr_i    = a0;
    way1_request_i = r1;
    way1_addr_i    = a1;
    mem_ack_i      = ack;
    mem_dataOk_i   = dok;
    mem_inst_i     = inst;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_memreq"}, 64'(mem_request_o), 64'd0);
    checkOutput({tag, "_memaddr"}, 64'(mem_addr_o), 64'd0);
    checkOutput({tag, "_grant0"}, 64'(way0_grant_o), 64'd0);
    checkOutput({tag, "_grant1"}, 64'(way1_grant_o), 64'd0);
    checkOutput({tag, "_dok0"}, 64'(way0_dataOk_o), 64'd0);
    checkOutput({tag, "_dok1"}, 64'(way1_dataOk_o), 64'd0);
    checkOutput({tag, "_inst0"}, 64'(way0_inst_o), 64'd0);
    checkOutput({tag, "_inst1"}, 64'(way1_inst_o), 64'd0);
    checkOutput({tag, "_timeout"}, 64'(timeout_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    logic exp_owner;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkAllZero("reset");

    // Single way0 fetch, response two cycles after the grant
    reset = 1'b0;
    applyStimulus(0, 1, 32'h100, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_memreq", 64'(mem_request_o), 64'd1);
    checkOutput("t1_addr", 64'(mem_addr_o), 64'h100);
    checkOutput("t1_grant0", 64'(way0_grant_o), 64'd1);
    checkOutput("t1_grant1", 64'(way1_grant_o), 64'd0);
    applyStimulus(0, 0, 32'h100, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_memreq_hold", 64'(mem_request_o), 64'd1);
    checkOutput("t1_addr_hold", 64'(mem_addr_o), 64'h100);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h13);
    @(negedge clk);
    checkOutput("t1_dok0", 64'(way0_dataOk_o), 64'd1);
    checkOutput("t1_inst0", 64'(way0_inst_o), 64'h13);
    checkOutput("t1_dok1", 64'(way1_dataOk_o), 64'd0);
    checkOutput("t1_inst1", 64'(way1_inst_o), 64'd0);
    checkOutput("t1_memreq_idle", 64'(mem_request_o), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_dok0_end", 64'(way0_dataOk_o), 64'd0);
    checkOutput("t1_inst0_hold", 64'(way0_inst_o), 64'h13);

    // Both ways requesting: grants alternate starting with way0 after reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 1, 32'h200, 1, 32'h300, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      exp_owner = (k % 2) == 1;
      @(negedge clk);
      checkOutput($sformatf("t2_grant0_%0d", k), 64'(way0_grant_o), 64'(!exp_owner));
      checkOutput($sformatf("t2_grant1_%0d", k), 64'(way1_grant_o), 64'(exp_owner));
      checkOutput($sformatf("t2_addr_%0d", k), 64'(mem_addr_o),
                  exp_owner ? 64'h300 : 64'h200);
      applyStimulus(0, 1, 32'h200, 1, 32'h300, 1, 1, 32'h1000 + k);
      @(negedge clk);
      checkOutput($sformatf("t2_dok0_%0d", k), 64'(way0_dataOk_o), 64'(!exp_owner));
      checkOutput($sformatf("t2_dok1_%0d", k), 64'(way1_dataOk_o), 64'(exp_owner));
      checkOutput($sformatf("t2_inst_%0d", k),
                  exp_owner ? 64'(way1_inst_o) : 64'(way0_inst_o), 64'h1000 + k);
      if (k == 3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      else        applyStimulus(0, 1, 32'h200, 1, 32'h300, 0, 0, 0);
    end

    // Flush while waiting: response is drained and discarded
    applyStimulus(0, 1, 32'h400, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t3_addr", 64'(mem_addr_o), 64'h400);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t3_wait_grant0", 64'(way0_grant_o), 64'd1);
    checkOutput("t3_wait_memreq", 64'(mem_request_o), 64'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t3_drop_grant0", 64'(way0_grant_o), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hDEAD);
    @(negedge clk);
    checkOutput("t3_dok0", 64'(way0_dataOk_o), 64'd0);
    checkOutput("t3_inst0", 64'(way0_inst_o), 64'h1002);
    checkOutput("t3_inst1", 64'(way1_inst_o), 64'h1003);
    applyStimulus(0, 0, 0, 1, 32'h500, 0, 0, 0);
    @(negedge clk);
    checkOutput("t3_new_memreq", 64'(mem_request_o), 64'd1);
    checkOutput("t3_new_addr", 64'(mem_addr_o), 64'h500);
    checkOutput("t3_new_grant1", 64'(way1_grant_o), 64'd1);

    // Flush in REQ before ack: request withdrawn, nothing delivered
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4_memreq", 64'(mem_request_o), 64'd0);
    checkOutput("t4_grant1", 64'(way1_grant_o), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4_dok1", 64'(way1_dataOk_o), 64'd0);
    checkOutput("t4_inst1", 64'(way1_inst_o), 64'h1003);

    // Flush in IDLE blocks a same-cycle request
    applyStimulus(1, 1, 32'h800, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4i_memreq", 64'(mem_request_o), 64'd0);
    checkOutput("t4i_grant0", 64'(way0_grant_o), 64'd0);

    // Timeout: ack but no response for MaxWait cycles in WAIT
    applyStimulus(0, 1, 32'h600, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t5_addr", 64'(mem_addr_o), 64'h600);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    pulses = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (timeout_o) pulses++;
    end
    checkOutput("t5_early_timeout", 64'(pulses), 64'd0);
    checkOutput("t5_still_waiting", 64'(way0_grant_o), 64'd1);
    @(negedge clk);
    checkOutput("t5_timeout", 64'(timeout_o), 64'd1);
    checkOutput("t5_idle_grant0", 64'(way0_grant_o), 64'd0);
    @(negedge clk);
    checkOutput("t5_timeout_end", 64'(timeout_o), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hBEEF);
    @(negedge clk);
    checkOutput("t5_stray_dok0", 64'(way0_dataOk_o), 64'd0);
    checkOutput("t5_stray_inst0", 64'(way0_inst_o), 64'h1002);

    // Reset in WAIT: everything clears and the late response is ignored
    applyStimulus(0, 0, 0, 1, 32'h700, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6_grant1", 64'(way1_grant_o), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t6_wait_grant1", 64'(way1_grant_o), 64'd1);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkAllZero("t6_reset");
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hCAFE);
    @(negedge clk);
    checkOutput("t6_late_dok1", 64'(way1_dataOk_o), 64'd0);
    checkOutput("t6_late_inst1", 64'(way1_inst_o), 64'd0);
    applyStimulus(0, 1, 32'h900, 1, 32'hA00, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6_next_grant0", 64'(way0_grant_o), 64'd1);
    checkOutput("t6_next_grant1", 64'(way1_grant_o), 64'd0);
    checkOutput("t6_next_addr", 64'(mem_addr_o), 64'h900);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
